fpga_bridge_fifo: RTL
=====================

Name: fpga_bridge_fifo

Overview:
Parametrised successor to the single-byte FPGA-to-FPGA bridge. It accepts words from the link receiver (`received` strobe), queues them in a DEPTH-entry synchronous FIFO, and forwards each word to the link transmitter with a start/busy handshake. It sits between the receiver and transmitter blocks and adds buffering, back-to-back forwarding and overflow reporting, none of which exist in the single-register version.

Parameters:
- DATA_WIDTH, 8: width of a transferred word.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- TIMEOUT, 255: cycles to wait for busy to rise after start (used only with the optional feature).

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset; 0 = reset, sampled on posedge clock.
- data_in  input  DATA_WIDTH  word from the receiver; valid while received=1.
- received  input  1  one-cycle strobe from the receiver.
- busy  input  1  transmitter busy flag.
- data_out  output  DATA_WIDTH  word presented to the transmitter; registered.
- transmit  output  1  start request to the transmitter.
- processed  output  1  one-cycle pulse after the transmitter finishes a word.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overflow  output  1  sticky; a word was dropped because the FIFO was full.
- tx_error  output  1  one-cycle timeout pulse; tied 0 without the optional feature.

Behaviour:
- Reset (reset=0 at posedge) forces the following, regardless of state:
  - state=IDLE; FIFO pointers and count=0.
  - data_out=0, transmit=0, processed=0, overflow=0, tx_error=0.
  - A word in flight is abandoned.
- Push: at a posedge with received=1 and !full, data_in is written at the write pointer.
  - received=1 while full: the word is dropped, FIFO unchanged, overflow set to 1 and held until reset.
- Pop: happens only on the IDLE->START transition. The head word is loaded into data_out and the read pointer advances.
- A push and a pop on the same edge are both allowed; count is unchanged. Push-while-full is still dropped even if a pop occurs on the same edge, because full is evaluated before the edge.
- Pointers wrap modulo DEPTH.
- Forwarding FSM (state-encoding constants live in the package):
  - IDLE: if !empty, pop -> START; else stay.
  - START: transmit=1. If busy=1 -> WAIT; else stay.
  - WAIT: transmit=0. If busy=0 -> DONE; else stay.
  - DONE: processed=1 for exactly one cycle -> IDLE.
- transmit and processed are decoded from the state register (Moore).
- data_out is stable from the pop edge until the next pop.
- Latency:
  - received sampled at edge N -> word stored at N; transmit high in the cycle after edge N+1, assuming the FIFO was empty and the FSM was in IDLE.
  - busy falling seen at edge M -> processed high for the cycle after M.
  - Minimum 4 cycles per word when busy is high for exactly 1 cycle.
- busy already high in IDLE is ignored. Forwarding is strictly one word at a time.

Optional Feature:
- Macro: FPGA_BRIDGE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to START and increments each START cycle.
  - If TIMEOUT cycles pass with busy=0, the FSM goes START->IDLE and tx_error pulses for 1 cycle; the word is discarded and processed is not asserted.
  - If busy rises on the same edge as the timeout, busy wins (goes to WAIT).
- Undefined: no counter; START waits indefinitely; tx_error is constant 0.

Decomposition:
- Package fpga_bridge_pkg: state constants (IDLE=0, START=1, WAIT=2, DONE=3), state width 2, default DATA_WIDTH/DEPTH.
- Sub-module bridge_sync_fifo:
  - Parametrised by DATA_WIDTH and DEPTH.
  - Provides push/pop/full/empty/count and overflow detection.
  - Synchronous active-low reset.
- The top level holds the FSM, the data_out register and the timeout.

Test Plan:
1. Reset held low 3 cycles mid-WAIT with count=2 -> after release: count=0, empty=1, data_out=0, transmit=0, overflow=0.
2. Single word 0xA5, busy high for 3 cycles after transmit -> data_out=0xA5; transmit high from 2 cycles after the strobe until busy=1; processed pulses once after busy falls; count returns to 0.
3. Burst of 4 strobes 0x01..0x04 on consecutive cycles with DEPTH=4, busy held high 5 cycles per word -> four processed pulses, data_out sequence 01,02,03,04, no overflow.
4. 6 strobes (0x10..0x15) back-to-back with busy stuck high -> first word popped and 4 queued (full=1), 0x15 dropped, overflow=1 stays high; after busy released, 0x10..0x14 are forwarded in order.
5. Simultaneous push and pop (received on the IDLE->START edge, count=1) -> count stays 1, the popped word is correct, and the new word follows next.
6. With FPGA_BRIDGE_TIMEOUT_EN and TIMEOUT=8, busy never rises -> tx_error pulses 8 cycles after START entry, FSM returns to IDLE, processed never asserts, and the next queued word starts.

Source files
------------

// File: rtl/fpga_bridge_pkg.sv
// Shared definitions for the FPGA bridge FIFO: forwarding FSM state encoding
// and default sizing.
package fpga_bridge_pkg;

    localparam int unsigned STATE_W            = 2;
    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH      = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fpga_bridge_fifo_if.sv
// Link-side bus of the bridge FIFO.
//   master : environment side (receiver strobe, transmitter busy; sees status)
//   slave  : bridge side (accepts words, drives transmitter request and status)
interface fpga_bridge_fifo_if #(
    parameter int unsigned DATA_WIDTH = fpga_bridge_pkg::DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = fpga_bridge_pkg::DEFAULT_DEPTH
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] data_in;
    logic                  received;
    logic                  busy;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  transmit;
    logic                  processed;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  tx_error;

    modport master (
        output data_in, received, busy,
        input  data_out, transmit, processed, count, full, empty, overflow, tx_error
    );

    modport slave (
        input  data_in, received, busy,
        output data_out, transmit, processed, count, full, empty, overflow, tx_error
    );

endinterface

// File: rtl/bridge_sync_fifo.sv
// Synchronous DEPTH-entry FIFO with sticky overflow detection.
// Ports:
//   clock, reset      : clock, synchronous active-low reset
//   push, push_data   : write request; ignored (and flagged) when full
//   pop               : read request; advances the read pointer when not empty
//   pop_data_c        : head word (combinational view of the read pointer)
//   count/full/empty  : registered occupancy status
//   overflow          : sticky, set when a push arrives while full
module bridge_sync_fifo
    import fpga_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      pop_data_c,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_nxt;
    logic                  full_q;
    logic                  empty_q;
    logic                  overflow_q;
    logic                  push_ok;
    logic                  pop_ok;

    // full/empty are the pre-edge values, so a push while full is dropped
    // even when a pop happens on the same edge.
    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty_q;

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_nxt = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count_q + CNT_W'(1);
            2'b01:   count_nxt = count_q - CNT_W'(1);
            default: count_nxt = count_q;
        endcase
    end

    // Pointers and status; power-of-two DEPTH lets the pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count_q    <= count_nxt;
            full_q     <= (count_nxt == CNT_W'(DEPTH));
            empty_q    <= (count_nxt == '0);
            overflow_q <= overflow_q | (push && full_q);
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    assign pop_data_c = mem[rd_ptr];
    assign count      = count_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign overflow   = overflow_q;

endmodule

// File: rtl/fpga_bridge_fifo.sv
// Buffered FPGA-to-FPGA bridge: queues received words and forwards them one
// at a time to the link transmitter with a start/busy handshake.
// Ports:
//   clock, reset : clock, synchronous active-low reset
//   bus (slave)  : data_in/received from the receiver, busy from the
//                  transmitter; data_out/transmit/processed to the
//                  transmitter; count/full/empty/overflow/tx_error status
// Optional build macro FPGA_BRIDGE_TIMEOUT_EN: abandon a word if busy does
// not rise within TIMEOUT cycles of the start request and pulse tx_error.
module fpga_bridge_fifo
    import fpga_bridge_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic          clock,
    input  logic          reset,
    fpga_bridge_fifo_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT == 0) begin : g_bad_cfg
        $error("fpga_bridge_fifo: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    state_t                state_q;
    state_t                state_nxt;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_c;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  transmit_q;
    logic                  processed_q;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_overflow;

    bridge_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (bus.received),
        .push_data  (bus.data_in),
        .pop        (pop),
        .pop_data_c (head_c),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .overflow   (fifo_overflow)
    );

`ifdef FPGA_BRIDGE_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_hit;
    logic             tx_error_q;
`endif

    // Forwarding FSM next state; the pop happens only on IDLE->START.
    always_comb begin
        state_nxt = state_q;
        pop       = 1'b0;
`ifdef FPGA_BRIDGE_TIMEOUT_EN
        tmo_hit   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                // busy rising on the timeout edge still wins
                if (bus.busy) begin
                    state_nxt = WAIT;
`ifdef FPGA_BRIDGE_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                    tmo_hit   = 1'b1;
`endif
                end
            end
            WAIT: begin
                if (!bus.busy) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register plus outputs registered from the next state so that
    // transmit/processed track the state register exactly.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            data_out_q  <= '0;
            transmit_q  <= 1'b0;
            processed_q <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            if (pop) data_out_q <= head_c;
            transmit_q  <= (state_nxt == START);
            processed_q <= (state_nxt == DONE);
        end
    end

`ifdef FPGA_BRIDGE_TIMEOUT_EN
    // Counts START cycles; cleared whenever the FSM is elsewhere so it starts
    // from zero on every START entry.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tmo_cnt_q  <= '0;
            tx_error_q <= 1'b0;
        end else begin
            if (state_q != START) tmo_cnt_q <= '0;
            else                  tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            tx_error_q <= tmo_hit;
        end
    end

    assign bus.tx_error = tx_error_q;
`else
    assign bus.tx_error = 1'b0;
`endif

    assign bus.data_out  = data_out_q;
    assign bus.transmit  = transmit_q;
    assign bus.processed = processed_q;
    assign bus.count     = fifo_count;
    assign bus.full      = fifo_full;
    assign bus.empty     = fifo_empty;
    assign bus.overflow  = fifo_overflow;

endmodule
